reg_bank_ctrl: RTL and testbench
================================

// Module: reg_bank_ctrl
// PURPOSE
//   Command-driven initiator for the 32x32 register bank (reg_bank).
//   Accepts WRITE/ADD/SUB/DUMP commands over a valid/ready handshake and sequences the bank ports.
//   Returns one result per command on a valid/ready response channel (DUMP returns 32 beats).
//   Sits between a test/host sequencer and reg_bank; the same reset also drives reg_bank.
// PARAMETERS
//   DATA_W    32  register width
//   ADDR_W    5   register index width
//   NUM_REGS  32  registers walked by DUMP (2**ADDR_W)
// PORTS
//   clk             in   1       clock; all state updates on rising edge
//   reset           in   1       reset, synchronous, active-high
//   cmd_valid       in   1       command present
//   cmd_ready       out  1       controller can accept a command
//   cmd_op          in   2       00 WRITE, 01 ADD, 10 SUB, 11 DUMP
//   cmd_dst         in   ADDR_W  destination index (WRITE/ADD/SUB)
//   cmd_src1        in   ADDR_W  first operand index (ADD/SUB)
//   cmd_src2        in   ADDR_W  second operand index (ADD/SUB)
//   cmd_imm         in   DATA_W  immediate (WRITE only)
//   rsp_valid       out  1       response beat present
//   rsp_ready       in   1       consumer accepts beat
//   rsp_data        out  DATA_W  value written / value dumped
//   rsp_idx         out  ADDR_W  register index of this beat
//   rsp_last        out  1       final beat of the command
//   rb_sr1          out  ADDR_W  bank read address 1
//   rb_sr2          out  ADDR_W  bank read address 2
//   rb_dr           out  ADDR_W  bank write address
//   rb_write        out  1       bank write enable
//   rb_write_data   out  DATA_W  bank write data
//   rb_read_data_1  in   DATA_W  bank read data 1 (combinational from rb_sr1)
//   rb_read_data_2  in   DATA_W  bank read data 2 (combinational from rb_sr2)
// BEHAVIOUR
//   States: IDLE, READ, WRITE, RESP, DUMP.
//   Reset: state=IDLE, cmd_ready=0 during reset, then 1. rsp_valid=0, rsp_last=0, rb_write=0.
//     All address/data outputs and internal registers are 0. Reset mid-operation drops the command.
//     No bank write is issued in the reset cycle or after it.
//   cmd_ready=1 only in IDLE (and not in reset). A command is accepted on cmd_valid&&cmd_ready.
//     On accept, op/dst/src/imm are latched; inputs are don't-care afterwards.
//   IDLE->WRITE on WRITE. IDLE->READ on ADD/SUB. IDLE->DUMP on DUMP (dump_idx=0).
//   READ (1 cycle): rb_sr1=src1 and rb_sr2=src2 are driven; result is latched at cycle end.
//     ADD: result = rd1 + rd2. SUB: result = rd1 - rd2. Both mod 2**DATA_W; carry/borrow discarded.
//   WRITE (1 cycle): rb_write=1, rb_dr=dst, rb_write_data=result (imm for WRITE op). Then ->RESP.
//   RESP: rsp_valid=1, rsp_data=result, rsp_idx=dst, rsp_last=1. All are held stable until rsp_ready.
//     On rsp_valid&&rsp_ready: ->IDLE.
//   Latency (accept edge = cycle 0): WRITE has rb_write in cycle 1 and rsp_valid from cycle 2.
//     ADD/SUB have rb_write in cycle 2 and rsp_valid from cycle 3.
//   Back-to-back: next accept is no earlier than the cycle after the response handshake.
//   DUMP: rb_sr1=dump_idx. rsp_valid=1, rsp_data=rb_read_data_1, rsp_idx=dump_idx.
//     rsp_last=(dump_idx==NUM_REGS-1). On handshake, dump_idx increments.
//     On the last handshake: ->IDLE. No bank writes occur during DUMP.
//   Backpressure: rsp_ready=0 stalls indefinitely in RESP/DUMP; no beat is lost or repeated.
//   Same-register cases: src1==src2 and dst==src are legal. Operands are read before the write.
//   rb_write is never high outside WRITE; rb_dr/rb_write_data are 0 when rb_write=0.
// STRUCTURE
//   reg_bank_pkg: op encodings (OP_WRITE..OP_DUMP), state enum, DATA_W/ADDR_W defaults.
//   Single module; no sub-module. The add/sub datapath is inline.
//   Integration: reg_bank_ctrl rb_* ports connect one-to-one to reg_bank ports. Shared clk/reset.
// TESTING (bench instantiates reg_bank_ctrl + reg_bank)
//   1. Reset then WRITE dst=3 imm=0xDEADBEEF -> rb_write at cycle 1.
//        Response (0xDEADBEEF, idx 3, last=1) at cycle 2.
//   2. WRITE r1=0xFFFFFFFF, r2=2; ADD dst=4 src1=1 src2=2 -> rsp_data=0x00000001 (wrap).
//        Then SUB dst=5 src1=2 src2=1 -> 0x00000003.
//   3. ADD dst=1 src1=1 src2=1 with r1=5 -> response 10, r1 == 10 afterwards.
//   4. DUMP after writes -> 32 beats, idx 0..31, data matches the model, rsp_last only on idx 31.
//        Randomly stall rsp_ready for 0-3 cycles; no drops or duplicates.
//   5. Assert reset in the READ cycle of an ADD -> no rb_write pulse, state IDLE.
//        A following DUMP returns all zeros.
//   6. Hold cmd_valid=1 while busy -> cmd_ready=0 until the response handshake.
//        Exactly one accept per command.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank and its command controller:
// command opcodes, controller states and default widths.
package reg_bank_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_DUMP  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP,
        ST_DUMP
    } state_e;

endpackage

// File: rtl/reg_bank.sv
// 2**ADDR_W x DATA_W register bank: two combinational read ports, one write
// port; synchronous reset clears every register.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    input  logic [ADDR_W-1:0] dr,
    input  logic              write,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2
);

    logic [DATA_W-1:0] regs_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write) begin
            regs_q[dr] <= write_data;
        end
    end

    assign read_data_1 = regs_q[sr1];
    assign read_data_2 = regs_q[sr2];

endmodule

// File: rtl/reg_bank_ctrl.sv
// Command-driven initiator for reg_bank: executes WRITE/ADD/SUB/DUMP commands
// and returns results on a valid/ready response channel.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [ADDR_W-1:0] cmd_src2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_idx,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] rb_sr1,
    output logic [ADDR_W-1:0] rb_sr2,
    output logic [ADDR_W-1:0] rb_dr,
    output logic              rb_write,
    output logic [DATA_W-1:0] rb_write_data,
    input  logic [DATA_W-1:0] rb_read_data_1,
    input  logic [DATA_W-1:0] rb_read_data_2
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] src1_q, src1_d;
    logic [ADDR_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [ADDR_W-1:0] dump_idx_q, dump_idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_WRITE;
            dst_q      <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            result_q   <= '0;
            dump_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            dst_q      <= dst_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            result_q   <= result_d;
            dump_idx_q <= dump_idx_d;
        end
    end

    // Outputs are forced idle while reset is held so no bank write can leak out.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        dst_d         = dst_q;
        src1_d        = src1_q;
        src2_d        = src2_q;
        result_d      = result_q;
        dump_idx_d    = dump_idx_q;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_idx       = '0;
        rsp_last      = 1'b0;
        rb_sr1        = '0;
        rb_sr2        = '0;
        rb_dr         = '0;
        rb_write      = 1'b0;
        rb_write_data = '0;

        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        op_d       = op_e'(cmd_op);
                        dst_d      = cmd_dst;
                        src1_d     = cmd_src1;
                        src2_d     = cmd_src2;
                        result_d   = cmd_imm;
                        dump_idx_d = '0;
                        unique case (op_e'(cmd_op))
                            OP_WRITE:       state_d = ST_WRITE;
                            OP_ADD, OP_SUB: state_d = ST_READ;
                            OP_DUMP:        state_d = ST_DUMP;
                            default:        state_d = ST_IDLE;
                        endcase
                    end
                end
                ST_READ: begin
                    rb_sr1   = src1_q;
                    rb_sr2   = src2_q;
                    result_d = (op_q == OP_SUB) ? rb_read_data_1 - rb_read_data_2
                                                : rb_read_data_1 + rb_read_data_2;
                    state_d  = ST_WRITE;
                end
                ST_WRITE: begin
                    rb_write      = 1'b1;
                    rb_dr         = dst_q;
                    rb_write_data = result_q;
                    state_d       = ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid = 1'b1;
                    rsp_data  = result_q;
                    rsp_idx   = dst_q;
                    rsp_last  = 1'b1;
                    if (rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DUMP: begin
                    rb_sr1    = dump_idx_q;
                    rsp_valid = 1'b1;
                    rsp_data  = rb_read_data_1;
                    rsp_idx   = dump_idx_q;
                    rsp_last  = (dump_idx_q == LAST_IDX);
                    if (rsp_ready) begin
                        dump_idx_d = dump_idx_q + 1'b1;
                        if (dump_idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl driving a real reg_bank; expected values come from an
// array model of the bank and from a table of hand-computed results.
module tb_reg_bank_ctrl;
    import reg_bank_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_dst, cmd_src1, cmd_src2;
    logic [DW-1:0] cmd_imm;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_idx;
    logic [AW-1:0] rb_sr1, rb_sr2, rb_dr;
    logic          rb_write;
    logic [DW-1:0] rb_write_data, rb_read_data_1, rb_read_data_2;

    always #5 clk = ~clk;

    reg_bank_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_idx(rsp_idx), .rsp_last(rsp_last),
        .rb_sr1(rb_sr1), .rb_sr2(rb_sr2), .rb_dr(rb_dr), .rb_write(rb_write),
        .rb_write_data(rb_write_data),
        .rb_read_data_1(rb_read_data_1), .rb_read_data_2(rb_read_data_2)
    );

    reg_bank #(.DATA_W(DW), .ADDR_W(AW)) bank (
        .clk(clk), .reset(reset),
        .sr1(rb_sr1), .sr2(rb_sr2), .dr(rb_dr), .write(rb_write),
        .write_data(rb_write_data),
        .read_data_1(rb_read_data_1), .read_data_2(rb_read_data_2)
    );

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] dst;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs [7];
    logic [DW-1:0] model [NR];
    int            n_pass = 0;
    int            n_total = 0;
    int            stable_err = 0;
    bit            stall_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] model_exp(input logic [1:0] op, input logic [AW-1:0] s1,
                                                input logic [AW-1:0] s2, input logic [DW-1:0] imm);
        case (op)
            2'b00:   return imm;
            2'b01:   return model[s1] + model[s2];
            2'b10:   return model[s1] - model[s2];
            default: return '0;
        endcase
    endfunction

    // Presents a command at a negedge; returns at the negedge after the accept edge.
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                            input logic [AW-1:0] s2, input logic [DW-1:0] imm);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_dst = AW'($urandom); cmd_src1 = AW'($urandom);
        cmd_src2 = AW'($urandom); cmd_imm = $urandom;
    endtask

    task automatic take_beat(output logic [DW-1:0] d, output logic [AW-1:0] idx,
                             output logic last, output logic ok);
        int n = 0;
        int k;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        ok = (rsp_valid === 1'b1);
        d = rsp_data; idx = rsp_idx; last = rsp_last;
        if (!ok) begin
            check("rsp_timeout", 32'd0, 32'd1);
        end else begin
            k = stall_en ? int'($urandom_range(0, 3)) : 0;
            repeat (k) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_idx !== idx || rsp_last !== last)
                    stable_err++;
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] s1,
                          input logic [AW-1:0] s2, input logic [DW-1:0] imm, output logic [DW-1:0] got);
        logic [DW-1:0] exp, d;
        logic [AW-1:0] idx;
        logic          last, ok;
        exp = model_exp(op, s1, s2, imm);
        send_cmd(op, dst, s1, s2, imm);
        take_beat(d, idx, last, ok);
        got = d;
        if (ok) begin
            check("rsp_data", d, exp);
            check("rsp_idx", 32'(idx), 32'(dst));
            check("rsp_last", 32'(last), 32'd1);
        end
        model[dst] = exp;
    endtask

    task automatic run_dump();
        logic [DW-1:0] d;
        logic [AW-1:0] idx;
        logic          last, ok;
        send_cmd(OP_DUMP, '0, '0, '0, '0);
        for (int i = 0; i < NR; i++) begin
            take_beat(d, idx, last, ok);
            if (ok) begin
                check("dump_idx", 32'(idx), 32'(i));
                check("dump_data", d, model[i]);
                check("dump_last", 32'(last), (i == NR - 1) ? 32'd1 : 32'd0);
            end
        end
        check("dump_end_valid", 32'(rsp_valid), 32'd0);
        check("dump_end_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] d;
        logic [AW-1:0] idx;
        logic          last, ok, bad;
        int            accepts;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src1 = '0;
        cmd_src2 = '0; cmd_imm = '0; rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        vecs[0] = '{2'b00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1] = '{2'b00, 5'd2, 5'd0, 5'd0, 32'h0000_0002, 32'h0000_0002};
        vecs[2] = '{2'b01, 5'd4, 5'd1, 5'd2, 32'h0,         32'h0000_0001};
        vecs[3] = '{2'b10, 5'd5, 5'd2, 5'd1, 32'h0,         32'h0000_0003};
        vecs[4] = '{2'b00, 5'd1, 5'd0, 5'd0, 32'h0000_0005, 32'h0000_0005};
        vecs[5] = '{2'b01, 5'd1, 5'd1, 5'd1, 32'h0,         32'h0000_000A};
        vecs[6] = '{2'b10, 5'd7, 5'd2, 5'd2, 32'h0,         32'h0000_0000};

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rb_write", 32'(rb_write), 32'd0);
        check("rst_rb_dr", 32'(rb_dr), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // WRITE latency: bank write in cycle 1, response from cycle 2
        send_cmd(OP_WRITE, 5'd3, 5'd0, 5'd0, 32'hDEAD_BEEF);
        check("wr_c1_rb_write", 32'(rb_write), 32'd1);
        check("wr_c1_rb_dr", 32'(rb_dr), 32'd3);
        check("wr_c1_wdata", rb_write_data, 32'hDEAD_BEEF);
        check("wr_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("wr_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("wr_c2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_c2_rsp_data", rsp_data, 32'hDEAD_BEEF);
        check("wr_c2_rsp_idx", 32'(rsp_idx), 32'd3);
        check("wr_c2_rsp_last", 32'(rsp_last), 32'd1);
        check("wr_c2_rb_write", 32'(rb_write), 32'd0);
        take_beat(d, idx, last, ok);
        model[3] = 32'hDEAD_BEEF;

        // ADD latency: read in cycle 1, write in cycle 2, response from cycle 3
        send_cmd(OP_ADD, 5'd6, 5'd3, 5'd3, '0);
        check("add_c1_rb_write", 32'(rb_write), 32'd0);
        check("add_c1_sr1", 32'(rb_sr1), 32'd3);
        check("add_c1_sr2", 32'(rb_sr2), 32'd3);
        @(negedge clk);
        check("add_c2_rb_write", 32'(rb_write), 32'd1);
        check("add_c2_rb_dr", 32'(rb_dr), 32'd6);
        check("add_c2_wdata", rb_write_data, 32'hBD5B_7DDE);
        check("add_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("add_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_c3_rsp_data", rsp_data, 32'hBD5B_7DDE);
        take_beat(d, idx, last, ok);
        model[6] = 32'hBD5B_7DDE;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2, vecs[i].imm, got);
            check($sformatf("tbl%0d", i), got, vecs[i].exp);
        end

        stall_en = 1'b1;
        run_dump();

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 2)), AW'($urandom), AW'($urandom), AW'($urandom),
                   $urandom, got);
        end
        run_dump();

        // Command held valid while busy: one accept, cmd_ready low until handshake
        rsp_ready = 1'b0;
        accepts = 0;
        bad = 1'b0;
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = 5'd9; cmd_imm = 32'h0000_1234;
        for (int c = 0; c < 8; c++) begin
            if (cmd_ready === 1'b1) accepts++;
            if (c > 0 && cmd_ready !== 1'b0) bad = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        check("hold_rsp_data", rsp_data, 32'h0000_1234);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("hold_accepts", 32'(accepts), 32'd1);
        check("hold_busy_ready", 32'(bad), 32'd0);
        @(negedge clk);
        check("hold_no_second_rsp", 32'(rsp_valid), 32'd0);
        model[9] = 32'h0000_1234;

        // Reset asserted in the READ cycle of an ADD drops the command
        send_cmd(OP_ADD, 5'd10, 5'd1, 5'd2, '0);
        reset = 1'b1;
        check("midrst_rb_write", 32'(rb_write), 32'd0);
        @(negedge clk);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_rb_write2", 32'(rb_write), 32'd0);
        reset = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rb_write !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) bad = 1'b1;
        end
        check("midrst_idle_after", 32'(bad), 32'd0);
        for (int i = 0; i < NR; i++) model[i] = '0;
        run_dump();

        check("beat_stability", 32'(stable_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
